// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers pixel timing from a TinyVGA PMOD byte stream, checks sync timing
// and reports the bounding box of lit pixels in the last complete locked frame.
module vga_rx_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_START  = 144,
  parameter int V_START  = 35,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] vga_in,
  output logic       locked,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [5:0] pix_rgb,
  output logic [9:0] bb_min_x,
  output logic [9:0] bb_max_x,
  output logic [9:0] bb_min_y,
  output logic [9:0] bb_max_y,
  output logic       bb_empty,
  output logic       frame_done,
  output logic [7:0] err_count
);
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
  state_t state, state_nxt;
  logic [7:0] s;
  logic hs_prev, vs_prev, hs_fall, vs_fall, hs_seen;
  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt, x, y;
  logic [5:0] rgb;
  logic active, lit, line_err, frame_err, tmo_err, err, upd;
  logic [9:0] run_min_x, run_max_x, run_min_y, run_max_y;
  logic run_lit;
  assign hs_fall = hs_prev & ~s[7];
  assign vs_fall = vs_prev & ~s[3];
  assign rgb = {s[0], s[4], s[1], s[5], s[2], s[6]};
  assign locked = state == LOCKED;
  // h_nxt/v_nxt are the coordinates of the sample now in stage S; the hsync-fall sample is column 0
  always_comb begin
    h_nxt = hs_fall ? 10'd0 : (h_cnt == 10'h3ff ? h_cnt : h_cnt + 10'd1);
    v_nxt = vs_fall ? {9'd0, hs_fall} : hs_fall ? (v_cnt == 10'h3ff ? v_cnt : v_cnt + 10'd1) : v_cnt;
    x = h_nxt - 10'(H_START);
    y = v_nxt - 10'(V_START);
    active = x < 10'(H_ACTIVE) && y < 10'(V_ACTIVE);
    lit = active && rgb != 6'd0 && state == LOCKED;
    line_err = hs_fall && hs_seen && ({1'b0, h_cnt} + 11'd1 != 11'(H_TOTAL));
    frame_err = vs_fall && v_cnt != 10'(V_TOTAL);
    tmo_err = !hs_fall && h_cnt == 10'(H_TOTAL + 16);
    err = line_err || frame_err || tmo_err;
    upd = vs_fall && state == LOCKED && !err;
    state_nxt = state == SEARCH ? (vs_fall ? ALIGN : SEARCH) : err ? SEARCH : vs_fall ? LOCKED : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
      s <= 8'h88;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      hs_seen <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
      err_count <= '0;
      pix_valid <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_rgb <= '0;
      bb_min_x <= '0;
      bb_max_x <= '0;
      bb_min_y <= '0;
      bb_max_y <= '0;
      bb_empty <= 1'b1;
      frame_done <= 1'b0;
      run_min_x <= 10'h3ff;
      run_max_x <= '0;
      run_min_y <= 10'h3ff;
      run_max_y <= '0;
      run_lit <= 1'b0;
    end else begin
      state <= state_nxt;
      s <= vga_in;
      hs_prev <= s[7];
      vs_prev <= s[3];
      hs_seen <= (state != SEARCH && state_nxt == SEARCH) ? 1'b0 : hs_seen | hs_fall;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (state != SEARCH && err && err_count != 8'hff) err_count <= err_count + 8'd1;
      pix_valid <= active && state == LOCKED;
      pix_x <= x;
      pix_y <= y;
      pix_rgb <= rgb;
      frame_done <= upd;
      if (upd) begin
        bb_min_x <= run_min_x;
        bb_max_x <= run_max_x;
        bb_min_y <= run_min_y;
        bb_max_y <= run_max_y;
        bb_empty <= !run_lit;
      end
      if (vs_fall) begin
        run_min_x <= 10'h3ff;
        run_max_x <= '0;
        run_min_y <= 10'h3ff;
        run_max_y <= '0;
        run_lit <= 1'b0;
      end else if (lit) begin
        run_min_x <= x < run_min_x ? x : run_min_x;
        run_max_x <= x > run_max_x ? x : run_max_x;
        run_min_y <= y < run_min_y ? y : run_min_y;
        run_max_y <= y > run_max_y ? y : run_max_y;
        run_lit <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed bench on a scaled-down 40x20 raster (24x12 active area).
module tb_vga_rx_monitor;
  localparam int HT = 40, VT = 20, HS = 8, VS = 4, HA = 24, VA = 12;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] vga_in = 8'h88;
  logic locked, pix_valid, bb_empty, frame_done;
  logic [9:0] pix_x, pix_y, bb_min_x, bb_max_x, bb_min_y, bb_max_y;
  logic [5:0] pix_rgb;
  logic [7:0] err_count;
  int total = 0, bad = 0, fd_cnt = 0;
  int rx0 = 1, rx1 = 0, ry0 = 1, ry1 = 0, long_l = -1;
  bit probe = 0;
  logic [5:0] color = 6'd63;
  bit pv[2];
  int px[2], py[2];
  logic [5:0] pc[2];

  vga_rx_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .clk(clk), .reset(reset), .vga_in(vga_in), .locked(locked), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .bb_min_x(bb_min_x), .bb_max_x(bb_max_x),
    .bb_min_y(bb_min_y), .bb_max_y(bb_max_y), .bb_empty(bb_empty), .frame_done(frame_done),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // pixel outputs trail the driven sample by two clocks
  task automatic step(input logic [7:0] b, input bit pr, input int x, input int y, input logic [5:0] c);
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
    if (pv[1]) begin
      chk("pix_x", pix_x, px[1]);
      chk("pix_y", pix_y, py[1]);
      chk("pix_rgb", pix_rgb, pc[1]);
      chk("pix_valid", pix_valid, 1);
    end
    pv[1] = pv[0]; px[1] = px[0]; py[1] = py[0]; pc[1] = pc[0];
    pv[0] = pr; px[0] = x; py[0] = y; pc[0] = c;
    vga_in = b;
  endtask

  task automatic run_lines(input int l0, input int l1);
    int x, y;
    bit lit;
    logic [5:0] c;
    for (int l = l0; l <= l1; l++)
      for (int h = 0; h < (l == long_l ? HT + 1 : HT); h++) begin
        x = h - HS;
        y = l + 1 - VS;
        lit = x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1 && x >= 0 && x < HA && y >= 0 && y < VA;
        c = lit ? color : 6'd0;
        step({h >= 4, c[0], c[2], c[4], l >= 2, c[1], c[3], c[5]}, lit && probe, x, y, c);
      end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h88, 1'b0, 0, 0, 6'd0);
  endtask

  task automatic set_box(input int a, input int b, input int c, input int d);
    rx0 = a; rx1 = b; ry0 = c; ry1 = d;
  endtask

  task automatic chk_bb(input string tag, input int a, input int b, input int c, input int d, input bit e);
    chk({tag, "_min_x"}, bb_min_x, a);
    chk({tag, "_max_x"}, bb_max_x, b);
    chk({tag, "_min_y"}, bb_min_y, c);
    chk({tag, "_max_y"}, bb_max_y, d);
    chk({tag, "_empty"}, bb_empty, e);
  endtask

  initial begin
    #12;
    chk("rst_locked", locked, 0);
    chk("rst_err", err_count, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk_bb("rst_bb", 0, 0, 0, 0, 1);
    @(negedge clk) reset = 1'b0;
    run_lines(0, VT - 1);
    chk("align_unlocked", locked, 0);
    fd_cnt = 0;
    run_lines(0, VT - 1);
    chk("lock_2nd_vs", locked, 1);
    chk("lock_err", err_count, 0);
    chk("no_fd_in_align", fd_cnt, 0);
    set_box(5, 12, 3, 8);
    run_lines(0, VT - 1);
    chk("fd_black", fd_cnt, 1);
    chk("black_empty", bb_empty, 1);
    fd_cnt = 0;
    set_box(0, 0, 0, 0);
    probe = 1;
    color = 6'b100110;
    run_lines(0, VT - 1);
    chk("fd_square", fd_cnt, 1);
    chk_bb("square", 5, 12, 3, 8, 0);
    set_box(HA - 1, HA - 1, VA - 1, VA - 1);
    run_lines(0, VT - 1);
    chk_bb("origin", 0, 0, 0, 0, 0);
    probe = 0;
    set_box(1, 0, 1, 0);
    long_l = 5;
    run_lines(0, VT - 1);
    long_l = -1;
    chk_bb("corner", HA - 1, HA - 1, VA - 1, VA - 1, 0);
    chk("line_err_count", err_count, 1);
    chk("line_err_unlock", locked, 0);
    fd_cnt = 0;
    run_lines(0, VT - 1);
    chk("relock_align", locked, 0);
    run_lines(0, VT - 1);
    chk("relock", locked, 1);
    chk("relock_err", err_count, 1);
    chk("held_fd", fd_cnt, 0);
    chk_bb("held", HA - 1, HA - 1, VA - 1, VA - 1, 0);
    idle(10);
    chk("pre_timeout_locked", locked, 1);
    idle(20);
    chk("timeout_unlock", locked, 0);
    chk("timeout_err", err_count, 2);
    idle(1000);
    chk("frozen_err", err_count, 2);
    chk("frozen_unlock", locked, 0);
    run_lines(0, VT - 1);
    set_box(5, 12, 3, 8);
    run_lines(0, VT - 1);
    chk("relock2", locked, 1);
    run_lines(0, 9);
    chk("pre_rst_bb_max_x", bb_max_x, 12);
    chk("pre_rst_empty", bb_empty, 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_pix_valid", pix_valid, 0);
    chk("mid_rst_pix_x", pix_x, 0);
    chk("mid_rst_pix_rgb", pix_rgb, 0);
    chk_bb("mid_rst_bb", 0, 0, 0, 0, 1);
    @(negedge clk) reset = 1'b0;
    pv[0] = 0;
    pv[1] = 0;
    run_lines(10, VT - 1);
    chk("post_rst_unlocked", locked, 0);
    run_lines(0, VT - 1);
    chk("post_rst_1st_vs", locked, 0);
    run_lines(0, VT - 1);
    chk("post_rst_2nd_vs", locked, 1);
    chk("post_rst_err", err_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 SHALL have parameter H_TOTAL, 800, clocks per line.
REQ-002 SHALL have parameter V_TOTAL, 525, lines per frame.
REQ-003 SHALL have parameter H_START, 144, clocks from hsync fall to first active pixel (sync 96 + back porch 48).
REQ-004 SHALL have parameter V_START, 35, hsync falls from vsync fall to first active line (sync 2 + back porch 33).
REQ-005 SHALL have parameters H_ACTIVE, 640, and V_ACTIVE, 480, active width and height.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port vga_in  input  8  TinyVGA PMOD byte {hsync, B0, G0, R0, vsync, B1, G1, R1}; syncs active-low.
REQ-009 SHALL have port locked  output  1  timing lock status.
REQ-010 SHALL have port pix_valid  output  1  pix_* hold an active, locked pixel.
REQ-011 SHALL have ports pix_x and pix_y  output  10 each  recovered pixel coordinates.
REQ-012 SHALL have port pix_rgb  output  6  {R1,R0,G1,G0,B1,B0}.
REQ-013 SHALL have ports bb_min_x, bb_max_x, bb_min_y, bb_max_y  output  10 each  bounding box of lit pixels, last complete frame.
REQ-014 SHALL have ports bb_empty  output  1  no lit pixel in that frame; frame_done  output  1  one-cycle pulse when bb_* update.
REQ-015 SHALL have port err_count  output  8  saturating timing-error count.

Function
REQ-016 SHALL register vga_in once (stage S); hs_fall / vs_fall = previous S sync 1 and current S sync 0.
REQ-017 SHALL run h_cnt (10 bit): 0 on hs_fall, else +1, saturating at 1023.
REQ-018 SHALL run v_cnt (10 bit): +1 on hs_fall, saturating at 1023; on vs_fall load 1 if hs_fall coincides, else 0.
REQ-019 SHALL define x = h_cnt - H_START, y = v_cnt - V_START (10-bit wrap); active when x < H_ACTIVE and y < V_ACTIVE (unsigned).
REQ-020 SHALL register pix_x, pix_y, pix_rgb every cycle, 2 clk after vga_in; pix_valid = active AND state LOCKED.
REQ-021 SHALL raise a line error on hs_fall when h_cnt+1 != H_TOTAL, but only once a previous hs_fall has been seen since entering SEARCH.
REQ-022 SHALL raise a frame error on vs_fall when v_cnt != V_TOTAL.
REQ-023 SHALL raise a timeout error when h_cnt reaches H_TOTAL+16 without hs_fall.
REQ-024 SHALL implement FSM SEARCH, ALIGN, LOCKED; locked = (state == LOCKED).
REQ-025 SHALL transition SEARCH -> ALIGN on vs_fall; all errors ignored in SEARCH.
REQ-026 SHALL transition ALIGN -> LOCKED on next vs_fall if no error that frame; any error -> SEARCH.
REQ-027 SHALL transition LOCKED -> SEARCH on any error; otherwise remain LOCKED.
REQ-028 SHALL increment err_count by 1 per cycle with an error in ALIGN or LOCKED; saturate at 255.
REQ-029 SHALL track running min/max x, y of active pixels with pix_rgb != 0 while LOCKED.
REQ-030 SHALL on vs_fall in LOCKED with no frame error copy running box to bb_*, set bb_empty if none lit, pulse frame_done next cycle.
REQ-031 SHALL reinitialise running box (min 1023, max 0, none lit) on every vs_fall.
REQ-032 SHALL hold bb_* unchanged on frames ending in error or outside LOCKED.

Reset
REQ-033 SHALL asynchronously on reset clear state to SEARCH, err_count 0, h_cnt/v_cnt 0, pix_* 0, bb_min_* 0, bb_max_* 0, bb_empty 1, frame_done 0, locked 0.
REQ-034 SHALL resume from SEARCH after reset mid-frame, needing two vs_fall to relock.

Verification
REQ-035 SHALL pass: standard 640x480 timing, black field -> locked 1 after 2nd vsync fall, err_count 0, bb_empty 1.
REQ-036 SHALL pass: white 128x128 square at (200,200) -> frame_done with bb = x 200..327, y 200..327, bb_empty 0.
REQ-037 SHALL pass: while locked, one line of 801 clocks -> err_count +1, locked 0, relock after two more frames.
REQ-038 SHALL pass: hsync stuck high while locked -> timeout at h_cnt 816, locked 0, err_count +1 then frozen in SEARCH.
REQ-039 SHALL pass: single lit pixel at (0,0) then at (639,479) -> pix_x/pix_y match 2 clk later; bb equals that point.
REQ-040 SHALL pass: reset asserted mid-frame at v_cnt 100 -> outputs at reset values immediately, locked 0 until 2nd vsync fall.
